// File: rtl/shared_mem_pkg.sv
// -----------------------------------------------------------------------------
// shared_mem_pkg
// Shared constants, types and helpers for the shared-memory round-robin
// arbiter. Imported by the bus interface, the arbiter core and the top level.
// -----------------------------------------------------------------------------
package shared_mem_pkg;

   localparam int MAX_MASTERS  = 8;
   localparam int DATA_W       = 32;
   localparam int BE_W         = 4;
   localparam int READ_LATENCY = 2;
   localparam int IDX_W        = $clog2(MAX_MASTERS);

   typedef logic [IDX_W-1:0] idx_t;

   // Kind of access being issued to the RAM in the current cycle.
   typedef enum logic [1:0] {
      ACC_NONE  = 2'd0,
      ACC_READ  = 2'd1,
      ACC_WRITE = 2'd2
   } acc_t;

   // Index "off" positions after "base", wrapping modulo n.
   // base is always < n and off <= n, so one subtraction is enough.
   function automatic idx_t rr_next(idx_t base, int off, int n);
      int sum;
      sum = int'(base) + off;
      if (sum >= n) begin
         sum = sum - n;
      end
      return idx_t'(sum);
   endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter_if
// Bundles the per-core Avalon-MM request/response buses (packed, master 0 in
// the LSBs) together with the pins of the single-port RAM.
//   slave  : arbiter view - takes core requests, drives the RAM and responses.
//   master : environment view - cores drive requests, RAM returns readdata.
// -----------------------------------------------------------------------------
interface shared_mem_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 13
);
   import shared_mem_pkg::*;

   // Core side
   logic [NUM_MASTERS*ADDR_W-1:0] m_address;
   logic [NUM_MASTERS*BE_W-1:0]   m_byteenable;
   logic [NUM_MASTERS-1:0]        m_read;
   logic [NUM_MASTERS-1:0]        m_write;
   logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
   logic [NUM_MASTERS-1:0]        m_waitrequest;
   logic [NUM_MASTERS*DATA_W-1:0] m_readdata;
   logic [NUM_MASTERS-1:0]        m_readdatavalid;

   // RAM side
   logic [ADDR_W-1:0]             mem_address;
   logic [BE_W-1:0]               mem_byteenable;
   logic                          mem_chipselect;
   logic                          mem_write;
   logic [DATA_W-1:0]             mem_writedata;
   logic                          mem_clken;
   logic [DATA_W-1:0]             mem_readdata;

   modport slave (
      input  m_address, m_byteenable, m_read, m_write, m_writedata,
      input  mem_readdata,
      output m_waitrequest, m_readdata, m_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write,
      output mem_writedata, mem_clken
   );

   modport master (
      output m_address, m_byteenable, m_read, m_write, m_writedata,
      output mem_readdata,
      input  m_waitrequest, m_readdata, m_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write,
      input  mem_writedata, mem_clken
   );

endinterface

// File: rtl/shared_mem_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin pointer and grant logic. The search starts one past the last
// granted master and wraps; the first requester found wins. The pointer only
// moves when a grant is actually issued.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : per-master request vector
//   accept       : grants are allowed this cycle (low forces no grant)
//   grant        : one-hot grant
//   grant_idx    : index of the granted master (don't-care when !grant_valid)
//   grant_valid  : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
   import shared_mem_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   accept,
   output logic [NUM_MASTERS-1:0] grant,
   output idx_t                   grant_idx,
   output logic                   grant_valid
);

   idx_t                   last_grant;
   logic [MAX_MASTERS-1:0] req_pad;
   logic                   found;
   idx_t                   sel_idx;

   // Pad to the full index range so any idx_t value selects a real bit.
   assign req_pad = MAX_MASTERS'(req);

   always_comb begin
      found   = 1'b0;
      sel_idx = last_grant;
      for (int off = 1; off <= MAX_MASTERS; off++) begin
         if ((off <= NUM_MASTERS) && !found &&
             req_pad[rr_next(last_grant, off, NUM_MASTERS)]) begin
            found   = 1'b1;
            sel_idx = rr_next(last_grant, off, NUM_MASTERS);
         end
      end
   end

   assign grant_valid = found & accept;
   assign grant_idx   = sel_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
         assign grant[gi] = grant_valid && (sel_idx == IDX_W'(gi));
      end
   endgenerate

   // Reset to the highest index so master 0 has first priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= IDX_W'(NUM_MASTERS - 1);
      end else if (grant_valid) begin
         last_grant <= sel_idx;
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
// Round-robin arbiter letting up to eight Avalon-MM cores share one single-port
// 32-bit RAM with 1-cycle read latency. At most one access is issued per cycle;
// read data returns to the requesting core two cycles after acceptance with a
// one-cycle readdatavalid pulse.
// Ports:
//   clk     : sole clock
//   reset_n : asynchronous active-low reset
//   bus     : core request/response buses and RAM pins (slave modport)
// -----------------------------------------------------------------------------
module shared_mem_arbiter
   import shared_mem_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 13
) (
   input  logic                 clk,
   input  logic                 reset_n,
   shared_mem_arbiter_if.slave  bus
);

   // Per-master request fields, padded to MAX_MASTERS so the grant index can
   // select directly without out-of-range entries.
   logic [ADDR_W-1:0]      addr_arr  [MAX_MASTERS];
   logic [BE_W-1:0]        be_arr    [MAX_MASTERS];
   logic [DATA_W-1:0]      wdata_arr [MAX_MASTERS];
   logic [MAX_MASTERS-1:0] wr_pad;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] grant;
   idx_t                   grant_idx;
   logic                   grant_valid;
   acc_t                   acc_kind;

   // Read-ID pipeline stage 1
   logic                   rd_v1;
   idx_t                   rd_id1;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_MASTERS; gi++) begin : g_unpack
         if (gi < NUM_MASTERS) begin : g_used
            assign addr_arr[gi]  = bus.m_address[gi*ADDR_W +: ADDR_W];
            assign be_arr[gi]    = bus.m_byteenable[gi*BE_W +: BE_W];
            assign wdata_arr[gi] = bus.m_writedata[gi*DATA_W +: DATA_W];
            assign wr_pad[gi]    = bus.m_write[gi];
         end else begin : g_unused
            assign addr_arr[gi]  = '0;
            assign be_arr[gi]    = '0;
            assign wdata_arr[gi] = '0;
            assign wr_pad[gi]    = 1'b0;
         end
      end
   endgenerate

   assign req = bus.m_read | bus.m_write;

   // Grants are suppressed while reset is asserted, so every core sees
   // waitrequest high and the RAM is not selected.
   rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_arbiter (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .accept      (reset_n),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Write wins when a core asserts read and write together; such an access
   // never produces readdatavalid.
   always_comb begin
      acc_kind = ACC_NONE;
      if (grant_valid) begin
         acc_kind = wr_pad[grant_idx] ? ACC_WRITE : ACC_READ;
      end
   end

   assign bus.m_waitrequest  = ~grant;

   assign bus.mem_address    = addr_arr[grant_idx];
   assign bus.mem_byteenable = be_arr[grant_idx];
   assign bus.mem_writedata  = wdata_arr[grant_idx];
   assign bus.mem_chipselect = grant_valid;
   assign bus.mem_write      = (acc_kind == ACC_WRITE);
   assign bus.mem_clken      = reset_n;

   // Stage 1: remember which master's read the RAM is servicing. The RAM
   // output is valid in the following cycle, when stage 2 captures it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_v1  <= 1'b0;
         rd_id1 <= '0;
      end else begin
         rd_v1  <= (acc_kind == ACC_READ);
         rd_id1 <= grant_idx;
      end
   end

   // Stage 2: per-master readdata registers hold their value until the next
   // completion for that master.
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
         logic              rdv_reg;
         logic [DATA_W-1:0] rdata_reg;
         logic              hit;

         assign hit = rd_v1 && (rd_id1 == IDX_W'(gi));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rdv_reg   <= 1'b0;
               rdata_reg <= '0;
            end else begin
               rdv_reg <= hit;
               if (hit) begin
                  rdata_reg <= bus.mem_readdata;
               end
            end
         end

         assign bus.m_readdatavalid[gi]          = rdv_reg;
         assign bus.m_readdata[gi*DATA_W +: DATA_W] = rdata_reg;
      end
   endgenerate

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
// Four-master bench around shared_mem_arbiter with a behavioural 1-cycle RAM.
// Accepted reads push their expected data into a queue; readdatavalid pulses
// pop and compare it, including the cycle at which it must arrive.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;
   import shared_mem_pkg::*;

   localparam int NM = 4;
   localparam int AW = 13;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   shared_mem_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW)) bus ();

   shared_mem_arbiter #(
      .NUM_MASTERS (NM),
      .ADDR_W      (AW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- stimulus drivers ----------------
   logic [NM-1:0] d_read;
   logic [NM-1:0] d_write;
   logic [AW-1:0] d_addr  [NM];
   logic [3:0]    d_be    [NM];
   logic [31:0]   d_wdata [NM];
   logic [31:0]   rd_of   [NM];

   assign bus.m_read  = d_read;
   assign bus.m_write = d_write;

   genvar gi;
   generate
      for (gi = 0; gi < NM; gi++) begin : g_pack
         assign bus.m_address[gi*AW +: AW]    = d_addr[gi];
         assign bus.m_byteenable[gi*4 +: 4]   = d_be[gi];
         assign bus.m_writedata[gi*32 +: 32]  = d_wdata[gi];
         assign rd_of[gi]                     = bus.m_readdata[gi*32 +: 32];
      end
   endgenerate

   // ---------------- RAM model ----------------
   function automatic logic [31:0] init_pat(int a);
      if (a == 16) return 32'hDEADBEEF;
      return 32'hC0DE0000 | 32'(a);
   endfunction

   bit   [31:0] ram    [8192];
   bit          ram_wr [8192];
   logic [31:0] ram_q;
   logic [31:0] ram_cur;
   int          ram_a;

   always @(posedge clk) begin
      if (bus.mem_clken && bus.mem_chipselect) begin
         ram_a   = int'(bus.mem_address);
         ram_cur = ram_wr[ram_a] ? ram[ram_a] : init_pat(ram_a);
         if (bus.mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.mem_byteenable[b]) ram_cur[b*8 +: 8] = bus.mem_writedata[b*8 +: 8];
            end
            ram[ram_a]    <= ram_cur;
            ram_wr[ram_a] <= 1'b1;
         end else begin
            ram_q <= ram_cur;
         end
      end
   end
   assign bus.mem_readdata = ram_q;

   // ---------------- scoreboard ----------------
   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        sb [$];
   bit   [31:0] model    [8192];
   bit          model_wr [8192];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model_rd(int a);
      return model_wr[a] ? model[a] : init_pat(a);
   endfunction

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] cur;
      int          a;
      if (!reset_n) begin
         checks++;
         if (bus.m_readdatavalid !== '0) begin
            failures++;
            $display("FAIL rdv_in_reset got=%b want=0000", bus.m_readdatavalid);
         end
         sb.delete();
      end else begin
         for (int i = 0; i < NM; i++) begin
            if (bus.m_readdatavalid[i] === 1'b1) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_rdv master=%0d data=%h cyc=%0d", i, rd_of[i], cyc);
               end else begin
                  e = sb.pop_front();
                  if (e.id != i || rd_of[i] !== e.data || e.due != cyc) begin
                     failures++;
                     $display("FAIL sb_read got master=%0d data=%h cyc=%0d want master=%0d data=%h cyc=%0d",
                              i, rd_of[i], cyc, e.id, e.data, e.due);
                  end
               end
            end
         end
         if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_rdv master=%0d want data=%h at cyc=%0d now=%0d",
                     sb[0].id, sb[0].data, sb[0].due, cyc);
            void'(sb.pop_front());
         end
         // Record what the arbiter accepted this cycle
         for (int i = 0; i < NM; i++) begin
            if ((d_read[i] | d_write[i]) && bus.m_waitrequest[i] === 1'b0) begin
               a = int'(d_addr[i]);
               if (d_write[i]) begin
                  cur = model_rd(a);
                  for (int b = 0; b < 4; b++) begin
                     if (d_be[i][b]) cur[b*8 +: 8] = d_wdata[i][b*8 +: 8];
                  end
                  model[a]    = cur;
                  model_wr[a] = 1'b1;
               end else begin
                  sb.push_back('{id: i, data: model_rd(a), due: cyc + 2});
               end
            end
         end
      end
   end

   // ---------------- helpers (no checking) ----------------
   task automatic set_m(int i, bit rd, bit wr, logic [AW-1:0] a, logic [3:0] be, logic [31:0] wd);
      d_read[i]  = rd;
      d_write[i] = wr;
      d_addr[i]  = a;
      d_be[i]    = be;
      d_wdata[i] = wd;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, '0, 4'h0, 32'h0);
   endtask

   task automatic do_reset(int n);
      @(posedge clk); #1;
      reset_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drain(int n);
      @(posedge clk); #1;
      idle_all();
      repeat (n) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.m_waitrequest !== 4'hF || bus.mem_clken !== 1'b0 || bus.mem_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got wr=%b clken=%b cs=%b want wr=1111 clken=0 cs=0",
                     bus.m_waitrequest, bus.mem_clken, bus.mem_chipselect);
         end
         checks++;
         if (bus.m_readdata !== '0) begin
            failures++;
            $display("FAIL reset_readdata got=%h want=0", bus.m_readdata);
         end
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_clken !== 1'b1 || bus.m_waitrequest !== 4'hF) begin
         failures++;
         $display("FAIL idle_after_reset got clken=%b wr=%b want clken=1 wr=1111",
                  bus.mem_clken, bus.m_waitrequest);
      end
   endtask

   task automatic test_single_read();
      @(posedge clk); #1;
      set_m(0, 1'b1, 1'b0, 13'h010, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.m_waitrequest !== 4'b1110) begin
         failures++;
         $display("FAIL single_wr got=%b want=1110", bus.m_waitrequest);
      end
      checks++;
      if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_address !== 13'h010) begin
         failures++;
         $display("FAIL single_mem got cs=%b we=%b addr=%h want cs=1 we=0 addr=0010",
                  bus.mem_chipselect, bus.mem_write, bus.mem_address);
      end
      @(posedge clk); #1;
      idle_all();
      @(negedge clk);
      checks++;
      if (bus.m_readdatavalid !== 4'b0000) begin
         failures++;
         $display("FAIL single_early_rdv got=%b want=0000", bus.m_readdatavalid);
      end
      @(negedge clk);
      checks++;
      if (bus.m_readdatavalid !== 4'b0001 || rd_of[0] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_rdv got rdv=%b data=%h want rdv=0001 data=deadbeef",
                  bus.m_readdatavalid, rd_of[0]);
      end
      @(negedge clk);
      checks++;
      if (bus.m_readdatavalid !== 4'b0000 || rd_of[0] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_pulse got rdv=%b data=%h want rdv=0000 data=deadbeef",
                  bus.m_readdatavalid, rd_of[0]);
      end
   endtask

   task automatic test_contention();
      logic [3:0] exp_wr;
      logic [3:0] exp_rdv;
      do_reset(2);
      set_m(0, 1'b1, 1'b0, 13'h001, 4'hF, 32'h0);
      set_m(1, 1'b1, 1'b0, 13'h002, 4'hF, 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_wr = ~(4'b0001 << (k % 2));
         checks++;
         if (bus.m_waitrequest !== exp_wr) begin
            failures++;
            $display("FAIL contention_grant k=%0d got=%b want=%b", k, bus.m_waitrequest, exp_wr);
         end
         if (k >= 2) begin
            exp_rdv = 4'b0001 << ((k - 2) % 2);
            checks++;
            if (bus.m_readdatavalid !== exp_rdv) begin
               failures++;
               $display("FAIL contention_rdv k=%0d got=%b want=%b", k, bus.m_readdatavalid, exp_rdv);
            end
         end
      end
      drain(3);
   endtask

   task automatic test_byte_write();
      @(posedge clk); #1;
      set_m(1, 1'b0, 1'b1, 13'h040, 4'hF, 32'hFFFFFFFF);
      @(negedge clk);
      checks++;
      if (bus.m_waitrequest !== 4'b1101) begin
         failures++;
         $display("FAIL bw_fill_wr got=%b want=1101", bus.m_waitrequest);
      end
      @(posedge clk); #1;
      set_m(1, 1'b0, 1'b1, 13'h040, 4'b0101, 32'h11223344);
      @(negedge clk);
      checks++;
      if (bus.mem_write !== 1'b1 || bus.mem_byteenable !== 4'b0101 ||
          bus.mem_writedata !== 32'h11223344 || bus.mem_address !== 13'h040) begin
         failures++;
         $display("FAIL bw_mem got we=%b be=%b wd=%h addr=%h want we=1 be=0101 wd=11223344 addr=0040",
                  bus.mem_write, bus.mem_byteenable, bus.mem_writedata, bus.mem_address);
      end
      @(posedge clk); #1;
      set_m(1, 1'b1, 1'b0, 13'h040, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.m_waitrequest !== 4'b1101 || bus.mem_write !== 1'b0) begin
         failures++;
         $display("FAIL bw_read_acc got wr=%b we=%b want wr=1101 we=0", bus.m_waitrequest, bus.mem_write);
      end
      @(posedge clk); #1;
      idle_all();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.m_readdatavalid !== 4'b0010 || rd_of[1] !== 32'hFF22FF44) begin
         failures++;
         $display("FAIL bw_readback got rdv=%b data=%h want rdv=0010 data=ff22ff44",
                  bus.m_readdatavalid, rd_of[1]);
      end
   endtask

   task automatic test_rw_both();
      @(posedge clk); #1;
      set_m(0, 1'b1, 1'b1, 13'h055, 4'hF, 32'hA5A5A5A5);
      @(negedge clk);
      checks++;
      if (bus.mem_write !== 1'b1 || bus.m_waitrequest[0] !== 1'b0) begin
         failures++;
         $display("FAIL rw_is_write got we=%b wr0=%b want we=1 wr0=0", bus.mem_write, bus.m_waitrequest[0]);
      end
      @(posedge clk); #1;
      set_m(0, 1'b1, 1'b0, 13'h055, 4'hF, 32'h0);
      @(negedge clk);
      @(posedge clk); #1;
      idle_all();
      @(negedge clk);
      checks++;
      if (bus.m_readdatavalid !== 4'b0000) begin
         failures++;
         $display("FAIL rw_no_rdv got=%b want=0000", bus.m_readdatavalid);
      end
      @(negedge clk);
      checks++;
      if (bus.m_readdatavalid !== 4'b0001 || rd_of[0] !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL rw_readback got rdv=%b data=%h want rdv=0001 data=a5a5a5a5",
                  bus.m_readdatavalid, rd_of[0]);
      end
   endtask

   task automatic test_reset_mid_read();
      @(posedge clk); #1;
      set_m(0, 1'b1, 1'b0, 13'h010, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.m_waitrequest[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_accept got wr0=%b want 0", bus.m_waitrequest[0]);
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      set_m(1, 1'b1, 1'b0, 13'h002, 4'hF, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.m_readdatavalid !== 4'b0000 || bus.m_waitrequest !== 4'hF || bus.mem_clken !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_reset k=%0d got rdv=%b wr=%b clken=%b want rdv=0000 wr=1111 clken=0",
                     k, bus.m_readdatavalid, bus.m_waitrequest, bus.mem_clken);
         end
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.m_waitrequest !== 4'b1110 || bus.m_readdatavalid !== 4'b0000) begin
         failures++;
         $display("FAIL mid_first_grant got wr=%b rdv=%b want wr=1110 rdv=0000",
                  bus.m_waitrequest, bus.m_readdatavalid);
      end
      @(posedge clk); #1;
      set_m(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.m_waitrequest !== 4'b1101) begin
         failures++;
         $display("FAIL mid_second_grant got=%b want=1101", bus.m_waitrequest);
      end
      drain(3);
   endtask

   task automatic test_rotation();
      logic [3:0] exp_wr [3];
      exp_wr[0] = 4'b1101;
      exp_wr[1] = 4'b0111;
      exp_wr[2] = 4'b1101;
      @(posedge clk); #1;
      set_m(3, 1'b0, 1'b1, 13'h070, 4'hF, 32'h00000001);
      @(negedge clk);
      checks++;
      if (bus.m_waitrequest !== 4'b0111) begin
         failures++;
         $display("FAIL rot_prime got=%b want=0111", bus.m_waitrequest);
      end
      @(posedge clk); #1;
      set_m(1, 1'b1, 1'b0, 13'h001, 4'hF, 32'h0);
      set_m(3, 1'b1, 1'b0, 13'h070, 4'hF, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.m_waitrequest !== exp_wr[k]) begin
            failures++;
            $display("FAIL rot_grant k=%0d got=%b want=%b", k, bus.m_waitrequest, exp_wr[k]);
         end
      end
      drain(4);
   endtask

   initial begin
      reset_n = 1'b0;
      idle_all();
      test_reset();
      test_single_read();
      test_contention();
      test_byte_write();
      test_rw_both();
      test_reset_mid_read();
      test_rotation();
      drain(3);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drained got=%0d pending want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
